// File: rtl/hall_call_register.sv
// Hall-call register: latches up/down call pulses per floor, arbitrates by traffic mode, offers one call at a time.
// Latency: request at edge N -> call_valid after edge N+1; at least one idle cycle between successive offers.
// Backpressure: offer holds stable until call_ready; calls keep latching meanwhile. HALL_LAMP_EN adds lamp outputs.
module hall_call_register #(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               request,
    input  logic [FLOOR_W-1:0] request_floor,
    input  logic               request_dir,
    input  logic [1:0]         traffic_state,
    output logic               call_valid,
    output logic [FLOOR_W-1:0] call_floor,
    output logic               call_dir,
    input  logic               call_ready
`ifdef HALL_LAMP_EN
    ,
    output logic [NUM_FLOORS-1:0] up_lamp,
    output logic [NUM_FLOORS-1:0] dn_lamp
`endif
);

    typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [NUM_FLOORS-1:0]   up_pend_q, up_pend_d;
    logic [NUM_FLOORS-1:0]   dn_pend_q, dn_pend_d;
    logic [FLOOR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [FLOOR_W-1:0]      call_floor_q, call_floor_d;
    logic                    call_dir_q, call_dir_d;

    logic [NUM_FLOORS-1:0]   up_set, dn_set, up_clr, dn_clr;
    logic [NUM_FLOORS-1:0]   up_rot, dn_rot;
    logic                    accept;
    logic                    any_pend;

    logic                    rr_found;
    logic [FLOOR_W-1:0]      rr_floor;
    logic                    rr_dir;
    logic                    up_found;
    logic [FLOOR_W-1:0]      up_low;
    logic                    dn_found;
    logic [FLOOR_W-1:0]      dn_high;
    logic [FLOOR_W-1:0]      pick_floor;
    logic                    pick_dir;

    assign accept   = (state_q == OFFER) && call_ready;
    assign any_pend = |{up_pend_q, dn_pend_q};

    // Calls that have no meaning (off the top, below the bottom, past the last floor) never set a bit.
    always_comb begin
        up_set = '0;
        dn_set = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (request && (int'(request_floor) == f)) begin
                if (request_dir && (f != NUM_FLOORS - 1)) up_set[f] = 1'b1;
                if (!request_dir && (f != 0))             dn_set[f] = 1'b1;
            end
        end
    end

    always_comb begin
        up_clr = '0;
        dn_clr = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (accept && (int'(call_floor_q) == f)) begin
                if (call_dir_q) up_clr[f] = 1'b1;
                else            dn_clr[f] = 1'b1;
            end
        end
    end

    // Set after clear: a fresh call for the floor being accepted stays pending.
    always_comb begin
        up_pend_d = (up_pend_q & ~up_clr) | up_set;
        dn_pend_d = (dn_pend_q & ~dn_clr) | dn_set;
    end

    // Round-robin scan: rotate so bit 0 is the floor at rr_ptr, then take the first occupied slot.
    always_comb begin
        up_rot = NUM_FLOORS'({up_pend_q, up_pend_q} >> rr_ptr_q);
        dn_rot = NUM_FLOORS'({dn_pend_q, dn_pend_q} >> rr_ptr_q);
    end

    always_comb begin
        int off;
        int idx;
        rr_found = 1'b0;
        rr_dir   = 1'b0;
        off      = 0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (!rr_found && (up_rot[i] || dn_rot[i])) begin
                rr_found = 1'b1;
                rr_dir   = up_rot[i];
                off      = i;
            end
        end
        idx = int'(rr_ptr_q) + off;
        if (idx >= NUM_FLOORS) idx = idx - NUM_FLOORS;
        rr_floor = FLOOR_W'(idx);
    end

    always_comb begin
        up_found = 1'b0;
        up_low   = '0;
        dn_found = 1'b0;
        dn_high  = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (!up_found && up_pend_q[f]) begin
                up_found = 1'b1;
                up_low   = FLOOR_W'(f);
            end
            if (dn_pend_q[f]) begin
                dn_found = 1'b1;
                dn_high  = FLOOR_W'(f);
            end
        end
    end

    always_comb begin
        pick_floor = rr_floor;
        pick_dir   = rr_dir;
        case (traffic_state)
            2'd1: if (up_found) begin
                pick_floor = up_low;
                pick_dir   = 1'b1;
            end
            2'd2: if (dn_found) begin
                pick_floor = dn_high;
                pick_dir   = 1'b0;
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            up_pend_q    <= '0;
            dn_pend_q    <= '0;
            rr_ptr_q     <= '0;
            call_floor_q <= '0;
            call_dir_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            up_pend_q    <= up_pend_d;
            dn_pend_q    <= dn_pend_d;
            rr_ptr_q     <= rr_ptr_d;
            call_floor_q <= call_floor_d;
            call_dir_q   <= call_dir_d;
        end
    end

    // Next-state and offer datapath
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        call_floor_d = call_floor_q;
        call_dir_d   = call_dir_q;
        case (state_q)
            IDLE: begin
                if (any_pend) begin
                    state_d      = OFFER;
                    call_floor_d = pick_floor;
                    call_dir_d   = pick_dir;
                end
            end
            OFFER: begin
                if (call_ready) begin
                    state_d  = IDLE;
                    rr_ptr_d = (int'(call_floor_q) == NUM_FLOORS - 1) ? '0
                                                                      : call_floor_q + FLOOR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        call_valid = (state_q == OFFER);
        call_floor = call_floor_q;
        call_dir   = call_dir_q;
    end

`ifdef HALL_LAMP_EN
    assign up_lamp = up_pend_q;
    assign dn_lamp = dn_pend_q;
`endif

endmodule

// File: tb/tb_hall_call_register.sv
// Directed bench for hall_call_register (8 floors, 4-bit floor bus so out-of-range floors can be driven).
module tb_hall_call_register;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       request = 1'b0;
    logic [3:0] request_floor = 4'd0;
    logic       request_dir = 1'b0;
    logic [1:0] traffic_state = 2'd0;
    logic       call_ready = 1'b0;
    logic       call_valid;
    logic [3:0] call_floor;
    logic       call_dir;
`ifdef HALL_LAMP_EN
    logic [7:0] up_lamp;
    logic [7:0] dn_lamp;
`endif

    int vectors = 0;
    int miscompares = 0;

    hall_call_register #(.NUM_FLOORS(8), .FLOOR_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .request       (request),
        .request_floor (request_floor),
        .request_dir   (request_dir),
        .traffic_state (traffic_state),
        .call_valid    (call_valid),
        .call_floor    (call_floor),
        .call_dir      (call_dir),
        .call_ready    (call_ready)
`ifdef HALL_LAMP_EN
        ,
        .up_lamp       (up_lamp),
        .dn_lamp       (dn_lamp)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] f, input logic d);
        request       = 1'b1;
        request_floor = f;
        request_dir   = d;
        cyc();
        request = 1'b0;
    endtask

    task automatic expect_offer(input string tag, input logic [3:0] f, input logic d);
        int n;
        n = 0;
        while (call_valid !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        chk({tag, "_valid"}, call_valid, 1);
        chk({tag, "_floor"}, call_floor, f);
        chk({tag, "_dir"}, call_dir, d);
    endtask

    task automatic accept(input string tag);
        call_ready = 1'b1;
        cyc();
        call_ready = 1'b0;
        chk({tag, "_drop"}, call_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset and idle
        #1 reset = 1'b0;
        cyc();
        cyc();
        chk("rst_valid", call_valid, 0);
        chk("rst_floor", call_floor, 0);
        chk("rst_dir", call_dir, 0);
`ifdef HALL_LAMP_EN
        chk("rst_lamps", {up_lamp, dn_lamp}, 0);
`endif
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("idle_valid", call_valid, 0);
            chk("idle_fd", {call_floor, call_dir}, 0);
        end

        // 2: single up call at floor 1, ready held high
        call_ready = 1'b1;
        pulse(4'd1, 1'b1);
        chk("lat_not_yet", call_valid, 0);
        cyc();
        chk("lat_valid", call_valid, 1);
        chk("lat_floor", call_floor, 1);
        chk("lat_dir", call_dir, 1);
        cyc();
        chk("served_drop", call_valid, 0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("served_quiet", call_valid, 0);
        end
        call_ready = 1'b0;

        // 3: up-peak; dn5/up6/up2 collected while up3 is on offer
        pulse(4'd3, 1'b1);
        pulse(4'd5, 1'b0);
        pulse(4'd6, 1'b1);
        pulse(4'd2, 1'b1);
        expect_offer("up_hold3", 4'd3, 1'b1);
        traffic_state = 2'd1;
        accept("up_acc3");
        expect_offer("up_peak2", 4'd2, 1'b1);
        traffic_state = 2'd2;
        cyc();
        cyc();
        chk("mode_chg_valid", call_valid, 1);
        chk("mode_chg_floor", call_floor, 2);
        chk("mode_chg_dir", call_dir, 1);
        traffic_state = 2'd1;
        accept("up_acc2");
        expect_offer("up_peak6", 4'd6, 1'b1);
        accept("up_acc6");
        expect_offer("up_fallback5", 4'd5, 1'b0);
        accept("up_acc5");
        traffic_state = 2'd0;

        // 4: normal round robin from rr_ptr=4
        pulse(4'd3, 1'b1);
        pulse(4'd1, 1'b1);
        pulse(4'd6, 1'b0);
        expect_offer("rr_first3", 4'd3, 1'b1);
        accept("rr_acc3");
        expect_offer("rr_dn6", 4'd6, 1'b0);
        accept("rr_acc6");
        expect_offer("rr_up1", 4'd1, 1'b1);
        accept("rr_acc1");

        // 5: meaningless calls leave no trace
        call_ready = 1'b1;
        pulse(4'd7, 1'b1);
        pulse(4'd0, 1'b0);
        pulse(4'd9, 1'b1);
        pulse(4'd9, 1'b0);
        pulse(4'd8, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("ignored_valid", call_valid, 0);
            cyc();
        end
`ifdef HALL_LAMP_EN
        chk("ignored_lamps", {up_lamp, dn_lamp}, 0);
`endif
        call_ready = 1'b0;

        // 6: collision on accept, then reset mid-offer
        pulse(4'd3, 1'b1);
        expect_offer("col_offer", 4'd3, 1'b1);
        call_ready    = 1'b1;
        request       = 1'b1;
        request_floor = 4'd3;
        request_dir   = 1'b1;
        cyc();
        call_ready = 1'b0;
        request    = 1'b0;
        chk("col_idle", call_valid, 0);
        cyc();
        chk("col_reoffer_valid", call_valid, 1);
        chk("col_reoffer_floor", call_floor, 3);
        chk("col_reoffer_dir", call_dir, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_valid", call_valid, 0);
        chk("async_rst_floor", call_floor, 0);
        chk("async_rst_dir", call_dir, 0);
        cyc();
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("post_rst_quiet", call_valid, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
